// File: rtl/issue_stage.sv
// In-order, single-issue uop stage steering decoded uops into four ALU lanes.
// A per-lane countdown scoreboard holds off RAW hazards and lane conflicts until writeback.
module issue_stage #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int OP_WIDTH      = 2,
   parameter int WB_LATENCY    = 1
) (
   input  logic                          clk_i,
   input  logic                          arst_i,
   input  logic                          uop_valid_i,
   output logic                          uop_ready_o,
   input  logic [1:0]                    uop_lane_i,
   input  logic [OP_WIDTH-1:0]           uop_op_i,
   input  logic [ADDRESS_WIDTH-1:0]      uop_src_a_i,
   input  logic [ADDRESS_WIDTH-1:0]      uop_src_b_i,
   input  logic [ADDRESS_WIDTH-1:0]      uop_src_c_i,
   input  logic [ADDRESS_WIDTH-1:0]      uop_dst_i,
   input  logic                          uop_we_i,
   input  logic                          flush_i,
   output logic [3:0][ADDRESS_WIDTH-1:0] select_a_o,
   output logic [3:0][ADDRESS_WIDTH-1:0] select_b_o,
   output logic [1:0][ADDRESS_WIDTH-1:0] select_c_o,
   output logic [3:0][ADDRESS_WIDTH-1:0] select_r_o,
   output logic [3:0]                    enable_writing_o,
   output logic [OP_WIDTH-1:0]           AB_op_o,
   output logic [OP_WIDTH-1:0]           LB_op_o,
   output logic [OP_WIDTH-1:0]           LSB_op_o,
   output logic [OP_WIDTH-1:0]           RSB_op_o,
   output logic                          busy_o
);

   localparam int CW = $clog2(WB_LATENCY + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WB_LATENCY);

   logic [3:0][CW-1:0]            cnt_q, cnt_d;
   logic [3:0][OP_WIDTH-1:0]      op_q, op_d;
   logic [3:0][ADDRESS_WIDTH-1:0] src_a_q, src_a_d;
   logic [3:0][ADDRESS_WIDTH-1:0] src_b_q, src_b_d;
   logic [1:0][ADDRESS_WIDTH-1:0] src_c_q, src_c_d;
   logic [3:0][ADDRESS_WIDTH-1:0] dst_q, dst_d;
   logic [3:0]                    we_q, we_d;

   logic lane_busy_s;
   logic raw_s;
   logic ready_s;
   logic accept_s;

   // Hazard detection: a lane at count 1 writes before the new uop reads, so it blocks nothing.
   always_comb begin
      lane_busy_s = (cnt_q[uop_lane_i] > CNT_ONE);
      raw_s       = 1'b0;
      for (int k = 0; k < 4; k++) begin
         raw_s = raw_s | (we_q[k] & (cnt_q[k] > CNT_ONE) &
                          ((dst_q[k] == uop_src_a_i) | (dst_q[k] == uop_src_b_i) |
                           (uop_lane_i[1] & (dst_q[k] == uop_src_c_i))));
      end
      ready_s  = arst_i & ~flush_i & ~lane_busy_s & ~raw_s;
      accept_s = uop_valid_i & ready_s;
   end

   // Next-state: flush clears all counters, accept reloads one lane, others count down.
   always_comb begin
      cnt_d   = cnt_q;
      op_d    = op_q;
      src_a_d = src_a_q;
      src_b_d = src_b_q;
      src_c_d = src_c_q;
      dst_d   = dst_q;
      we_d    = we_q;
      for (int l = 0; l < 4; l++) begin
         if (flush_i) begin
            cnt_d[l] = '0;
         end else if (accept_s && (uop_lane_i == 2'(l))) begin
            cnt_d[l]   = CNT_LOAD;
            op_d[l]    = uop_op_i;
            src_a_d[l] = uop_src_a_i;
            src_b_d[l] = uop_src_b_i;
            dst_d[l]   = uop_dst_i;
            we_d[l]    = uop_we_i;
         end else if (cnt_q[l] != '0) begin
            cnt_d[l] = cnt_q[l] - CNT_ONE;
         end else begin
            cnt_d[l] = cnt_q[l];
         end
      end
      if (accept_s && uop_lane_i[1]) begin
         src_c_d[uop_lane_i[0]] = uop_src_c_i;
      end else begin
         src_c_d = src_c_q;
      end
   end

   // Lane state registers.
   always_ff @(posedge clk_i or negedge arst_i) begin
      if (!arst_i) begin
         cnt_q   <= '0;
         op_q    <= '0;
         src_a_q <= '0;
         src_b_q <= '0;
         src_c_q <= '0;
         dst_q   <= '0;
         we_q    <= '0;
      end else begin
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         src_a_q <= src_a_d;
         src_b_q <= src_b_d;
         src_c_q <= src_c_d;
         dst_q   <= dst_d;
         we_q    <= we_d;
      end
   end

   // Write enables and busy decode straight from state so async reset drops them at once.
   always_comb begin
      busy_o = 1'b0;
      for (int l = 0; l < 4; l++) begin
         enable_writing_o[l] = (cnt_q[l] == CNT_ONE) & we_q[l];
         busy_o              = busy_o | (cnt_q[l] != '0);
      end
   end

   assign uop_ready_o = ready_s;
   assign select_a_o  = src_a_q;
   assign select_b_o  = src_b_q;
   assign select_c_o  = src_c_q;
   assign select_r_o  = dst_q;
   assign AB_op_o     = op_q[0];
   assign LB_op_o     = op_q[1];
   assign LSB_op_o    = op_q[2];
   assign RSB_op_o    = op_q[3];

endmodule

// File: tb/tb_issue_stage.sv
// Randomized bench: three issue_stage instances (WB_LATENCY 1,2,3) share stimulus and are
// compared against a timestamp-based model of in-flight uops.
module tb_issue_stage;

   logic       clk;
   logic       arst_i;
   logic       uop_valid_i;
   logic [1:0] uop_lane_i;
   logic [1:0] uop_op_i;
   logic [4:0] uop_src_a_i, uop_src_b_i, uop_src_c_i, uop_dst_i;
   logic       uop_we_i;
   logic       flush_i;

   logic            ready  [3];
   logic [3:0][4:0] sel_a  [3];
   logic [3:0][4:0] sel_b  [3];
   logic [1:0][4:0] sel_c  [3];
   logic [3:0][4:0] sel_r  [3];
   logic [3:0]      wen    [3];
   logic [1:0]      ab_op  [3];
   logic [1:0]      lb_op  [3];
   logic [1:0]      lsb_op [3];
   logic [1:0]      rsb_op [3];
   logic            busy   [3];

   int n_checks = 0;
   int n_errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      issue_stage #(.ADDRESS_WIDTH(5), .OP_WIDTH(2), .WB_LATENCY(g + 1)) u_dut (
         .clk_i            (clk),
         .arst_i           (arst_i),
         .uop_valid_i      (uop_valid_i),
         .uop_ready_o      (ready[g]),
         .uop_lane_i       (uop_lane_i),
         .uop_op_i         (uop_op_i),
         .uop_src_a_i      (uop_src_a_i),
         .uop_src_b_i      (uop_src_b_i),
         .uop_src_c_i      (uop_src_c_i),
         .uop_dst_i        (uop_dst_i),
         .uop_we_i         (uop_we_i),
         .flush_i          (flush_i),
         .select_a_o       (sel_a[g]),
         .select_b_o       (sel_b[g]),
         .select_c_o       (sel_c[g]),
         .select_r_o       (sel_r[g]),
         .enable_writing_o (wen[g]),
         .AB_op_o          (ab_op[g]),
         .LB_op_o          (lb_op[g]),
         .LSB_op_o         (lsb_op[g]),
         .RSB_op_o         (rsb_op[g]),
         .busy_o           (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each lane remembers its last uop and the cycle its write lands.
   int         now;
   bit         m_alive [3][4];
   int         m_wc    [3][4];
   bit         m_we    [3][4];
   logic [1:0] m_op    [3][4];
   logic [4:0] m_a     [3][4];
   logic [4:0] m_b     [3][4];
   logic [4:0] m_dst   [3][4];
   logic [4:0] m_c     [3][2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, now);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 3; d++) begin
         for (int l = 0; l < 4; l++) begin
            m_alive[d][l] = 1'b0;
            m_wc[d][l]    = 0;
            m_we[d][l]    = 1'b0;
            m_op[d][l]    = 2'd0;
            m_a[d][l]     = 5'd0;
            m_b[d][l]     = 5'd0;
            m_dst[d][l]   = 5'd0;
         end
         m_c[d][0] = 5'd0;
         m_c[d][1] = 5'd0;
      end
   endtask

   function automatic bit exp_ready(int d);
      int ln;
      ln = int'(uop_lane_i);
      if (!arst_i || flush_i) return 1'b0;
      if (m_alive[d][ln] && now < m_wc[d][ln]) return 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (m_alive[d][k] && m_we[d][k] && now < m_wc[d][k] &&
             (m_dst[d][k] == uop_src_a_i || m_dst[d][k] == uop_src_b_i ||
              (ln >= 2 && m_dst[d][k] == uop_src_c_i)))
            return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [3:0] exp_wen(int d);
      logic [3:0] e;
      for (int l = 0; l < 4; l++) e[l] = m_alive[d][l] && m_we[d][l] && (now == m_wc[d][l]);
      return e;
   endfunction

   function automatic bit exp_busy(int d);
      bit b;
      b = 1'b0;
      for (int l = 0; l < 4; l++) if (m_alive[d][l] && now <= m_wc[d][l]) b = 1'b1;
      return b;
   endfunction

   task automatic check_all();
      logic [3:0][4:0] ea, eb, er;
      logic [1:0][4:0] ec;
      for (int d = 0; d < 3; d++) begin
         for (int l = 0; l < 4; l++) begin
            ea[l] = m_a[d][l];
            eb[l] = m_b[d][l];
            er[l] = m_dst[d][l];
         end
         ec[0] = m_c[d][0];
         ec[1] = m_c[d][1];
         check_eq($sformatf("L%0d ready", d + 1), 64'(ready[d]), 64'(exp_ready(d)));
         check_eq($sformatf("L%0d enable", d + 1), 64'(wen[d]), 64'(exp_wen(d)));
         check_eq($sformatf("L%0d busy", d + 1), 64'(busy[d]), 64'(exp_busy(d)));
         check_eq($sformatf("L%0d sel_a", d + 1), 64'(sel_a[d]), 64'(ea));
         check_eq($sformatf("L%0d sel_b", d + 1), 64'(sel_b[d]), 64'(eb));
         check_eq($sformatf("L%0d sel_c", d + 1), 64'(sel_c[d]), 64'(ec));
         check_eq($sformatf("L%0d sel_r", d + 1), 64'(sel_r[d]), 64'(er));
         check_eq($sformatf("L%0d ops", d + 1), 64'({rsb_op[d], lsb_op[d], lb_op[d], ab_op[d]}),
                  64'({m_op[d][3], m_op[d][2], m_op[d][1], m_op[d][0]}));
      end
   endtask

   // Applies the clock edge that ends the current cycle to the model.
   task automatic model_step();
      int ln;
      ln = int'(uop_lane_i);
      if (!arst_i) begin
         model_reset();
      end else begin
         for (int d = 0; d < 3; d++) begin
            if (uop_valid_i && exp_ready(d)) begin
               m_alive[d][ln] = 1'b1;
               m_wc[d][ln]    = now + d + 1;
               m_we[d][ln]    = uop_we_i;
               m_op[d][ln]    = uop_op_i;
               m_a[d][ln]     = uop_src_a_i;
               m_b[d][ln]     = uop_src_b_i;
               m_dst[d][ln]   = uop_dst_i;
               if (ln >= 2) m_c[d][ln - 2] = uop_src_c_i;
            end else if (flush_i) begin
               for (int l = 0; l < 4; l++) m_alive[d][l] = 1'b0;
            end
         end
      end
      now++;
   endtask

   function automatic logic [4:0] rnd_reg();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin
      int resets_done;
      bit want_rst;
      resets_done = 0;
      now         = 0;
      arst_i      = 1'b0;
      uop_valid_i = 1'b0;
      uop_lane_i  = 2'd0;
      uop_op_i    = 2'd0;
      uop_src_a_i = 5'd0;
      uop_src_b_i = 5'd0;
      uop_src_c_i = 5'd0;
      uop_dst_i   = 5'd0;
      uop_we_i    = 1'b0;
      flush_i     = 1'b0;
      model_reset();

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge clk);
         #1;
         arst_i      = (cyc >= 3);
         uop_valid_i = ($urandom_range(0, 3) != 0);
         uop_lane_i  = 2'($urandom_range(0, 3));
         uop_op_i    = 2'($urandom_range(0, 3));
         uop_src_a_i = rnd_reg();
         uop_src_b_i = rnd_reg();
         uop_src_c_i = rnd_reg();
         uop_dst_i   = rnd_reg();
         uop_we_i    = ($urandom_range(0, 4) != 0);
         flush_i     = ($urandom_range(0, 15) == 0);

         // Occasionally drop reset mid-cycle while the WB_LATENCY=2 instance is writing.
         want_rst = (cyc > 50) && (resets_done < 4) && (exp_wen(1) != 4'b0000) &&
                    ($urandom_range(0, 5) == 0);
         if (want_rst) begin
            #1;
            check_eq("pre_rst enable", 64'(wen[1]), 64'(exp_wen(1)));
            arst_i = 1'b0;
            #1;
            for (int d = 0; d < 3; d++) begin
               check_eq($sformatf("L%0d async_rst enable", d + 1), 64'(wen[d]), 64'd0);
               check_eq($sformatf("L%0d async_rst busy", d + 1), 64'(busy[d]), 64'd0);
               check_eq($sformatf("L%0d async_rst ready", d + 1), 64'(ready[d]), 64'd0);
            end
            model_reset();
            resets_done++;
         end

         @(negedge clk);
         check_all();
         model_step();
      end

      if (resets_done == 0) begin
         check_eq("mid_op resets exercised", 64'(resets_done), 64'd1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
